// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: producer-side write signals, consumer-side read signals and status flags.
// master drives requests and write data; slave (the FIFO) returns data, flags and occupancy.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  empty;
    logic                  almost_empty;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output wr_en, data_in, rd_en,
        input  full, almost_full, overflow, data_out, data_valid,
               empty, almost_empty, underflow, count
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output full, almost_full, overflow, data_out, data_valid,
               empty, almost_empty, underflow, count
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and error pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; the default build uses a registered read.
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t ONE      = ptr_t'(1);
    localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
    localparam ptr_t AFULL_C  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t count_q;
    ptr_t count_nxt;

    logic full_q;
    logic almost_full_q;
    logic empty_q;
    logic almost_empty_q;
    logic overflow_q;
    logic underflow_q;
    logic wr_acc;
    logic rd_acc;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_idx = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr[ADDR_WIDTH-1:0];

    // NOTE: every variable gets a value before any branch so always_comb never infers a latch.
    always_comb begin
        wr_acc    = bus.wr_en & (~full_q | bus.rd_en);
        rd_acc    = bus.rd_en & ~empty_q;
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + ONE;
            2'b01:   count_nxt = count_q - ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Flags are derived from the next occupancy so they land on the same edge as count.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            count_q        <= count_nxt;
            full_q         <= (count_nxt == DEPTH_C);
            almost_full_q  <= (count_nxt >= AFULL_C);
            empty_q        <= (count_nxt == '0);
            almost_empty_q <= (count_nxt <= AEMPTY_C);
            overflow_q     <= bus.wr_en & full_q & ~bus.rd_en;
            underflow_q    <= bus.rd_en & empty_q;
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which words are live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_idx] <= bus.data_in;
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is shown as soon as it exists; driving zero while empty keeps the bus free of stale data.
    assign bus.data_out   = empty_q ? '0 : mem[rd_idx];
    assign bus.data_valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_acc;
            if (rd_acc) data_q <= mem[rd_idx];
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = data_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised successor to the 8x8 synchronous FIFO: configurable data width and depth, plus occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Single clock domain. Sits between producer and consumer stages that need flow control with early-warning thresholds.
- Storage is a register array indexed by binary read/write pointers carrying an extra wrap bit.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 words).
- AFULL_THRESH, 6, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; deassertion is synchronous to clk upstream.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.
- overflow  output  1  one-cycle pulse when a write is rejected.
- rd_en  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- data_valid  output  1  data_out holds a freshly popped word.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- underflow  output  1  one-cycle pulse when a read is rejected.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset values (asynchronous, immediate): wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, data_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- Acceptance rules, evaluated on the pre-edge state:
  - wr_acc = wr_en & (~full | rd_en). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
  - rd_acc = rd_en & ~empty. A read on an empty FIFO is always rejected, even with a simultaneous write; there is no bypass.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Pointers advance by 1 modulo 2**(ADDR_WIDTH+1) on acceptance; the low ADDR_WIDTH bits index memory. Wrap-around is seamless.
- All flags are registered and updated on the same edge as count, so they reflect post-edge occupancy with no combinational paths from inputs.
- Read latency (standard mode): on rd_acc, data_out is loaded at that edge with mem[rd_ptr]; data_valid=1 for exactly that following cycle. Otherwise data_valid=0 and data_out holds its last value.
- overflow=1 for one cycle after an edge where wr_en & full & ~rd_en. Memory and pointers are unchanged.
- underflow=1 for one cycle after an edge where rd_en & empty. data_out is unchanged and data_valid=0.
- Reset asserted mid-operation: all state clears immediately, and in-flight data is discarded.

Optional Feature:
- Macro FIFO_SYNC_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever ~empty; rd_en pops the displayed word.
  - data_valid = ~empty.
  - Reset data_valid=0.
- Undefined: standard registered-read behaviour as specified above.

Test Plan:
- Reset: assert reset mid-clock -> all outputs take reset values immediately; count=0, empty=1, almost_empty=1.
- Fill: write 0..7 on consecutive cycles ->
  - almost_empty clears after the 2nd write;
  - almost_full sets after the 6th write;
  - full=1 and count=8 after the 8th write.
- Overflow: at full, wr_en=1, rd_en=0, data_in=0xAA -> overflow pulses one cycle; count stays 8; a later drain returns 0..7 with no 0xAA.
- Drain: rd_en for 8 cycles -> data_out = 0..7 in order, each with data_valid=1 one cycle after its rd_en; empty=1 at the end. A 9th read -> underflow pulses, data_valid=0.
- Simultaneous and wrap: write 5, read 5, then write 0x10..0x17 -> reads return 0x10..0x17. At full, assert wr_en and rd_en together with 0x55 -> count stays 8 and 0x55 is read last.
- FWFT build (FIFO_SYNC_FWFT_EN): write 0x3C into an empty FIFO -> data_out=0x3C with data_valid=1 the cycle after the write edge, before any rd_en.
